// File: rtl/apb_slave.sv
`default_nettype none
// ============================================================================
//  Module      : apb_slave
//  Description : APB completer with MEM_DEPTH x DATA_WIDTH register storage,
//                word-indexed addressing, zero wait states and error response
//                on out-of-range addresses or missing setup phase.
//  Revision    : 1.0  initial release
// ============================================================================
module apb_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,   // active-high despite the name
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int c_IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] c_DEPTH = ADDR_WIDTH'(MEM_DEPTH);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;
    localparam logic [1:0] c_ST_ERROR  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_xfer;
    logic                  w_addr_valid;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_bad_state;
    logic                  w_wr_en;
    logic                  w_err;

    // Full-width compare so high address bits never alias into the array.
    assign w_addr_valid = (PADDR < c_DEPTH);
    assign w_idx        = PADDR[c_IDX_W-1:0];
    assign w_xfer       = PSEL & PENABLE;
    assign w_bad_state  = (r_state == c_ST_IDLE) | (r_state == c_ST_ERROR);

    // Only the access phase that follows a genuine setup phase may write.
    assign w_wr_en = (r_state == c_ST_SETUP) & w_xfer & PWRITE & w_addr_valid;

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode from the bus handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (PSEL && !PENABLE)     w_state_nxt = c_ST_SETUP;
                else if (PSEL && PENABLE) w_state_nxt = c_ST_ERROR;
                else                      w_state_nxt = c_ST_IDLE;
            end
            c_ST_SETUP: begin
                if (!PSEL)                w_state_nxt = c_ST_IDLE;
                else if (PENABLE)         w_state_nxt = c_ST_ACCESS;
                else                      w_state_nxt = c_ST_SETUP;
            end
            c_ST_ACCESS, c_ST_ERROR: begin
                // Holding PENABLE keeps the current state; no new transfer starts.
                if (!PSEL)                w_state_nxt = c_ST_IDLE;
                else if (!PENABLE)        w_state_nxt = c_ST_SETUP;
                else                      w_state_nxt = r_state;
            end
            default:                      w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Storage array: cleared by reset, written once at the end of a valid access.
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_idx] <= PWDATA;
        end
    end

    // Combinational response; reset forces every output low.
    always_comb begin
        w_err   = w_xfer & (~w_addr_valid | w_bad_state);
        PREADY  = ~PRESETn & w_xfer;
        PSLVERR = ~PRESETn & w_err;
        PRDATA  = '0;
        if (~PRESETn && w_xfer && !PWRITE && w_addr_valid && !w_err) begin
            PRDATA = r_mem[w_idx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_slave
//  Description : Directed self-checking bench for apb_slave.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_slave;

    logic        PCLK;
    logic        PRESETn;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int          n_cmp;
    int          n_mis;
    logic [31:0] d_arr [16];

    apb_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (16)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PREADY  (PREADY),
        .PRDATA  (PRDATA),
        .PSLVERR (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        @(negedge PCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    // Setup then access phase; returns just after the completing edge.
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic exp_err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        #1 check($sformatf("wr%0d_setup_ready", a), 32'(PREADY), 32'd0);
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        check($sformatf("wr%0d_ready", a), 32'(PREADY), 32'd1);
        check($sformatf("wr%0d_slverr", a), 32'(PSLVERR), 32'(exp_err));
        @(posedge PCLK);
    endtask

    task automatic apb_read(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        check($sformatf("rd%0d_data", a), PRDATA, exp_d);
        check($sformatf("rd%0d_ready", a), 32'(PREADY), 32'd1);
        check($sformatf("rd%0d_slverr", a), 32'(PSLVERR), 32'(exp_err));
        @(posedge PCLK);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        for (int i = 0; i < 16; i++) d_arr[i] = $urandom | 32'h1;

        // Reset held with an access phase on the bus: outputs must stay low.
        PRESETn = 1'b1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'd0; PWDATA = 32'd0;
        #1;
        check("rst_ready", 32'(PREADY), 32'd0);
        check("rst_slverr", 32'(PSLVERR), 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b0;

        // All words read zero after reset, back-to-back reads.
        for (int i = 0; i < 16; i++) apb_read(32'(i), 32'd0, 1'b0);
        bus_idle();

        // Write every word back-to-back, then read back.
        for (int i = 0; i < 16; i++) apb_write(32'(i), d_arr[i], 1'b0);
        bus_idle();
        for (int i = 0; i < 16; i++) apb_read(32'(i), d_arr[i], 1'b0);
        bus_idle();
        apb_read(32'd15, d_arr[15], 1'b0);
        bus_idle();

        // Out-of-range write with PENABLE held for a second cycle.
        apb_write(32'd1055, 32'hDEADBEEF, 1'b1);
        @(negedge PCLK);
        #1;
        check("oor_hold_ready", 32'(PREADY), 32'd1);
        check("oor_hold_slverr", 32'(PSLVERR), 32'd1);
        @(posedge PCLK);
        bus_idle();
        for (int i = 0; i < 16; i++) apb_read(32'(i), d_arr[i], 1'b0);
        apb_read(32'd1055, 32'd0, 1'b1);
        // Index bits of 1055 alias word 15; full compare must reject it.
        apb_read(32'h0000_0010, 32'd0, 1'b1);
        bus_idle();

        // Access phase straight from IDLE: error, and held in ERROR, no write.
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'd2; PWDATA = 32'hCAFEF00D;
        #1;
        check("pv_slverr", 32'(PSLVERR), 32'd1);
        check("pv_ready", 32'(PREADY), 32'd1);
        @(negedge PCLK);
        #1;
        check("pv_hold_slverr", 32'(PSLVERR), 32'd1);
        check("pv_hold_prdata", PRDATA, 32'd0);
        bus_idle();
        apb_read(32'd2, d_arr[2], 1'b0);
        bus_idle();

        // Reset asserted during the setup phase of a write to word 3.
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'd3; PWDATA = 32'h12345678;
        #2 PRESETn = 1'b1;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        check("mrst_ready", 32'(PREADY), 32'd0);
        check("mrst_slverr", 32'(PSLVERR), 32'd0);
        @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        apb_read(32'd3, 32'd0, 1'b0);
        apb_read(32'd15, 32'd0, 1'b0);
        bus_idle();

        // Normal operation after reset release.
        apb_write(32'd5, 32'h0BADF00D, 1'b0);
        apb_read(32'd5, 32'h0BADF00D, 1'b0);
        bus_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width.
- MEM_DEPTH, 16, number of storage words.
REQ-002 Ports SHALL be, in this order, one per line:
- PCLK  in  1  single clock, all state on rising edge.
- PRESETn  in  1  reset; asynchronous, active-high (asserted at 1 despite the name suffix).
- PADDR  in  ADDR_WIDTH  word index (not byte address).
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase strobe.
- PWRITE  in  1  1=write, 0=read.
- PWDATA  in  DATA_WIDTH  write data.
- PREADY  out  1  transfer ready.
- PRDATA  out  DATA_WIDTH  read data.
- PSLVERR  out  1  transfer error.
REQ-003 No PSTRB or PPROT ports; every write is full-word.

Function
REQ-004 Storage SHALL be MEM_DEPTH words of DATA_WIDTH bits.
REQ-005 An address SHALL be valid iff PADDR < MEM_DEPTH, compared over the full ADDR_WIDTH bits (no truncation or aliasing).
REQ-006 FSM states SHALL be IDLE, SETUP, ACCESS and ERROR, registered on PCLK.
REQ-007 IDLE transitions: PSEL&!PENABLE -> SETUP; PSEL&PENABLE -> ERROR (protocol violation: no setup phase); otherwise stay in IDLE.
REQ-008 SETUP transitions: PSEL&PENABLE -> ACCESS (transfer completes on this edge); PSEL&!PENABLE -> SETUP; !PSEL -> IDLE.
REQ-009 ACCESS and ERROR transitions: !PSEL -> IDLE; PSEL&!PENABLE -> SETUP; PSEL&PENABLE -> stay in the same state (master holding, no new transfer).
REQ-010 Access cycle SHALL be the cycle in which state==SETUP and PSEL&PENABLE.
REQ-011 PREADY SHALL be combinational, PSEL&PENABLE, in every state (zero wait states; the master can never hang).
REQ-012 PSLVERR SHALL be combinational, PSEL&PENABLE&(address invalid OR state is IDLE or ERROR).
REQ-013 Write SHALL commit mem[PADDR] <= PWDATA at the rising edge ending an access cycle with PWRITE=1 and a valid address.
REQ-014 No write SHALL occur when the address is invalid, on a protocol violation, or while held in ACCESS/ERROR.
REQ-015 PRDATA SHALL be combinational: mem[PADDR] when PSEL&PENABLE&!PWRITE, address valid and PSLVERR=0; otherwise all zeros.
REQ-016 Read data SHALL reflect the pre-edge memory contents; there is no same-cycle write-to-read bypass.
REQ-017 Back-to-back transfers (ACCESS -> SETUP without passing through IDLE) SHALL be supported.
REQ-018 Bus inputs are not registered; outputs are valid in the same cycle the access phase is presented.

Reset
REQ-019 While PRESETn=1, asynchronously: state SHALL be IDLE, all memory words 0, and PREADY=0, PSLVERR=0, PRDATA=0, overriding REQ-011/012/015.
REQ-020 Reset asserted mid-transfer SHALL abort the transfer with no memory write.
REQ-021 Normal operation SHALL resume on the first rising edge after PRESETn returns to 0.

Verification
REQ-022 Reset scenario: pulse PRESETn=1 for 1 cycle, then read addresses 0..15 -> PRDATA=0, PREADY=1 and PSLVERR=0 in each access cycle.
REQ-023 Write-all scenario: for i=0..15, setup cycle (PSEL=1, PENABLE=0, PWRITE=1, PADDR=i, PWDATA=random Di), then access cycle -> PREADY=1 and PSLVERR=0 each time; then read each i -> PRDATA=Di.
REQ-024 Read-15 scenario: read addr 15 after writing D15 -> PRDATA=D15 and PREADY=1 in the access cycle.
REQ-025 Out-of-range scenario: write PADDR=1055, PWDATA=0xDEADBEEF, PENABLE held 2 cycles -> PREADY=1 and PSLVERR=1 in both cycles; all 16 words unchanged; a subsequent read of 1055 -> PRDATA=0 and PSLVERR=1.
REQ-026 Protocol-violation and mid-transfer reset scenario: PSEL=PENABLE=1 from IDLE -> PSLVERR=1 and no write; separately, assert reset during the setup phase of a write to addr 3 -> mem[3] stays 0.
